// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the control unit and the
// multi-cycle multiply/divide engine.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, A, B,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Signed radix-2 Booth multiply and restoring divide, one
// iteration per clock, results presented on hi/lo.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic            clock,
   input  logic            clear_n,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE, PREP, ITER, FIXUP, DONE
   } state_t;

   state_t state, nxt;

   logic             op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] mq;
   logic [WIDTH:0]   md;
   logic             aux;
   logic             sign_q, sign_r;
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             dz_r;

   logic             zdiv;
   logic [WIDTH:0]   amag, bmag;
   logic [WIDTH:0]   bsum;
   logic [WIDTH:0]   rsh, rnew;
   logic             ge;

   // Operand magnitudes and single-step Booth/divide arithmetic.
   always_comb begin
      zdiv = op_q && (b_q == '0);
      amag = a_q[WIDTH-1] ? (~{1'b1, a_q} + 1'b1) : {1'b0, a_q};
      bmag = b_q[WIDTH-1] ? (~{1'b1, b_q} + 1'b1) : {1'b0, b_q};
      unique case ({mq[0], aux})
         2'b01:   bsum = acc + md;
         2'b10:   bsum = acc - md;
         default: bsum = acc;
      endcase
      rsh  = {acc[WIDTH-1:0], mq[WIDTH-1]};
      ge   = (rsh >= md);
      rnew = ge ? (rsh - md) : rsh;
   end

   // State register.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= IDLE;
      else          state <= nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      nxt      = state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         IDLE:  if (bus.start) nxt = PREP;
         PREP: begin
            bus.busy = 1'b1;
            // Divide by zero skips the iterations entirely.
            nxt = zdiv ? FIXUP : ITER;
         end
         ITER: begin
            bus.busy = 1'b1;
            if (cnt == CW'(WIDTH - 1)) nxt = FIXUP;
         end
         FIXUP: begin
            bus.busy = 1'b1;
            nxt      = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            nxt      = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and result registers.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         op_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         cnt    <= '0;
         acc    <= '0;
         mq     <= '0;
         md     <= '0;
         aux    <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         dz_r   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q <= bus.op;
                  a_q  <= bus.A;
                  b_q  <= bus.B;
                  dz_r <= 1'b0;
               end
            end
            PREP: begin
               cnt <= '0;
               acc <= '0;
               aux <= 1'b0;
               if (!op_q) begin
                  mq <= b_q;
                  md <= {a_q[WIDTH-1], a_q};
               end else begin
                  sign_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                  sign_r <= a_q[WIDTH-1];
                  mq     <= amag[WIDTH-1:0];
                  md     <= bmag;
               end
            end
            ITER: begin
               cnt <= cnt + CW'(1);
               if (!op_q) begin
                  {acc, mq, aux} <= {bsum[WIDTH], bsum, mq};
               end else begin
                  acc <= rnew;
                  mq  <= {mq[WIDTH-2:0], ge};
               end
            end
            FIXUP: begin
               if (zdiv) begin
                  hi_r <= a_q;
                  lo_r <= '1;
                  dz_r <= 1'b1;
               end else if (!op_q) begin
                  hi_r <= acc[WIDTH-1:0];
                  lo_r <= mq;
               end else begin
                  lo_r <= sign_q ? -mq : mq;
                  hi_r <= sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for the multi-cycle multiply/divide engine.
// Expected results are queued at issue and checked on done.
module tb_muldiv_sequencer;
   logic clock;
   logic clear_n;
   int   checks = 0;
   int   errors = 0;
   int   dones  = 0;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } res_t;

   res_t sbq[$];

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic res_t model(logic op, logic [31:0] a,
                                  logic [31:0] b);
      res_t   m;
      longint p;
      int     q, r;
      if (!op) begin
         p = longint'($signed(a)) * longint'($signed(b));
         m.hi = p[63:32];
         m.lo = p[31:0];
         m.dz = 1'b0;
      end else if (b == 32'h0) begin
         m.hi = a;
         m.lo = 32'hFFFF_FFFF;
         m.dz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         m.hi = 32'h0;
         m.lo = 32'h8000_0000;
         m.dz = 1'b0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
         m.hi = r;
         m.lo = q;
         m.dz = 1'b0;
      end
      return m;
   endfunction

   // Scoreboard: compare each done pulse with the oldest expectation.
   always @(negedge clock) begin
      if (bus.done) begin
         res_t r;
         dones++;
         check("sb_avail", 64'(sbq.size() != 0), 64'(1));
         if (sbq.size() != 0) begin
            r = sbq.pop_front();
            check("hi", 64'(bus.hi), 64'(r.hi));
            check("lo", 64'(bus.lo), 64'(r.lo));
            check("div_zero", 64'(bus.div_zero), 64'(r.dz));
         end
      end
   end

   task automatic run_op(logic op, logic [31:0] a, logic [31:0] b,
                         int lat, int pulse_at);
      int n, bn, d0;
      sbq.push_back(model(op, a, b));
      d0 = dones;
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.op    = 1'($urandom);
      bus.A     = $urandom;
      bus.B     = $urandom;
      n  = 0;
      bn = bus.busy ? 1 : 0;
      while (!bus.done && n < 100) begin
         @(posedge clock);
         #1;
         n++;
         if (n == pulse_at) begin
            bus.start = 1'b1;
            bus.op    = ~op;
            bus.A     = 32'h0000_1234;
            bus.B     = 32'h0000_0003;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.busy) bn++;
      end
      check("latency", 64'(n), 64'(lat));
      check("busy_cycles", 64'(bn), 64'(lat));
      check("busy_at_done", 64'(bus.busy), 64'(0));
      @(posedge clock);
      #1;
      check("one_done", 64'(dones - d0), 64'(1));
      check("idle_busy", 64'(bus.busy), 64'(0));
   endtask

   initial begin
      int d0, n;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      clear_n   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ctl",
            64'({bus.busy, bus.done, bus.div_zero}), 64'(0));
      check("rst_res", {bus.hi, bus.lo}, 64'(0));
      @(negedge clock);
      clear_n = 1'b1;

      run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 34, -1);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 34, -1);
      run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 34, -1);
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 34, -1);
      run_op(1'b1, 32'd100, 32'd7, 34, -1);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, -1);
      run_op(1'b1, 32'd5, 32'd0, 2, -1);
      run_op(1'b0, 32'd2, 32'd3, 34, -1);
      run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 34, -1);
      run_op(1'b1, 32'd17, 32'hFFFF_FFFB, 34, -1);

      // Start pulsed mid-iteration must be ignored.
      run_op(1'b0, 32'h0001_0001, 32'hFFFF_0003, 34, 10);

      for (int i = 0; i < 6; i++) begin
         logic        rop;
         logic [31:0] ra, rb;
         rop = 1'($urandom);
         ra  = $urandom;
         rb  = (i == 2) ? 32'h0 : $urandom_range(0, 2000) - 1000;
         run_op(rop, ra, rb, (rop && rb == 0) ? 2 : 34, -1);
      end

      // Reset in the middle of iterating: no done, outputs cleared.
      d0 = dones;
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.A     = 32'd11;
      bus.B     = 32'd13;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (21) @(posedge clock);
      #2;
      clear_n = 1'b0;
      #1;
      check("rst_mid_ctl",
            64'({bus.busy, bus.done, bus.div_zero}), 64'(0));
      check("rst_mid_res", {bus.hi, bus.lo}, 64'(0));
      repeat (3) @(posedge clock);
      #1;
      check("rst_no_done", 64'(dones - d0), 64'(0));
      @(negedge clock);
      clear_n = 1'b1;
      run_op(1'b1, 32'd9, 32'd3, 34, -1);

      // start held high: back-to-back operations.
      d0 = dones;
      sbq.push_back(model(1'b0, 32'd6, 32'hFFFF_FFF9));
      sbq.push_back(model(1'b0, 32'd6, 32'hFFFF_FFF9));
      @(negedge clock);
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.A     = 32'd6;
      bus.B     = 32'hFFFF_FFF9;
      n = 0;
      while (dones - d0 < 2 && n < 200) begin
         @(negedge clock);
         n++;
      end
      bus.start = 1'b0;
      check("held_start_dones", 64'(dones - d0), 64'(2));
      repeat (40) @(posedge clock);
      #1;
      check("held_start_stop", 64'(dones - d0), 64'(2));
      check("sb_drained", 64'(sbq.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
